// File: rtl/strobe_ack_rx_pkg.sv
// -----------------------------------------------------------------------------
// strobe_pkg
// Shared definitions for the toggle-flag strobe receiver:
//   - receiver FSM state encoding
//   - minimum synchroniser depth
//   - statistics counter widths and a saturating-increment helper
// -----------------------------------------------------------------------------
package strobe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int MIN_DELAY = 2;

  localparam int RX_CNT_W  = 16;
  localparam int OVR_CNT_W = 8;

  // Saturating increment for the dropped-event counter (sticks at all-ones).
  function automatic logic [OVR_CNT_W-1:0] sat_inc_ovr(input logic [OVR_CNT_W-1:0] v);
    logic [OVR_CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(OVR_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/strobe_ack_rx_toggle_sync.sv
// -----------------------------------------------------------------------------
// toggle_sync
// Multi-flop synchroniser for a level-toggle flag plus change detector.
// Usable at either end of the crossing (req on the destination side, ack on
// the source side).
//
// Ports:
//   clk      in   sampling clock
//   rst_n    in   asynchronous active-low reset
//   i_toggle in   toggle flag from the other clock domain
//   o_level  out  synchronised level of the flag
//   o_event  out  one-cycle pulse when the synchronised level changes
// -----------------------------------------------------------------------------
module toggle_sync
  import strobe_pkg::*;
#(
  parameter int DELAY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_toggle,
  output logic o_level,
  output logic o_event
);

  // Depths below the metastability minimum are raised to it.
  localparam int D = (DELAY < MIN_DELAY) ? MIN_DELAY : DELAY;

  logic [D:0] r_sync;

  // Shift the asynchronous flag through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[D-1:0], i_toggle};
    end
  end

  assign o_level = r_sync[D];
  // Compares the two oldest stages, so the pulse is fully synchronised.
  assign o_event = r_sync[D] ^ r_sync[D-1];

endmodule

// File: rtl/strobe_ack_rx.sv
// -----------------------------------------------------------------------------
// strobe_ack_rx
// Destination end of a toggle-flag strobe crossing. Synchronises req_toggle,
// captures the quasi-static req_data bus when the flag flips, presents it on a
// valid/ready handshake and flips ack_toggle once the word is consumed.
//
// Ports:
//   clk          in   destination clock
//   rst_n        in   asynchronous active-low reset
//   req_toggle   in   source flag (asynchronous); each change is one transfer
//   req_data     in   source data, stable around each transfer
//   data_out     out  captured word (held while data_valid is low)
//   data_valid   out  data_out holds an unconsumed word
//   data_ready   in   consumer accepts the word
//   ack_toggle   out  flips once per consumed word
//   overrun      out  sticky: a protocol-violating event was dropped
//   overrun_clr  in   clears overrun (a same-cycle set wins)
//   rx_count     out  [STROBE_ACK_RX_STATS_EN] completed handshakes, wraps
//   ovr_count    out  [STROBE_ACK_RX_STATS_EN] dropped events, saturates
//
// Build option: define STROBE_ACK_RX_STATS_EN to add the two statistics
// counters and their ports.
// -----------------------------------------------------------------------------
module strobe_ack_rx
  import strobe_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DELAY       = 2,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_toggle,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             ack_toggle,
  output logic             overrun,
  input  logic             overrun_clr
`ifdef STROBE_ACK_RX_STATS_EN
  ,
  output logic [RX_CNT_W-1:0]  rx_count,
  output logic [OVR_CNT_W-1:0] ovr_count
`endif
);

  localparam int HC = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int CW = (HC > 1) ? $clog2(HC) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HC - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ack;
  logic             r_overrun;
  logic             r_pending;
  logic [CW-1:0]    r_cnt;

  logic             w_event;
  logic             w_unused_level;
  logic             w_drop;
  logic             w_handshake;

  // The receiver only needs the change pulse; the level is left for the source side.
  toggle_sync #(
    .DELAY (DELAY)
  ) u_req_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_toggle (req_toggle),
    .o_level  (w_unused_level),
    .o_event  (w_event)
  );

  // Classify events that cannot be accepted: any event while a word is
  // outstanding, or a second event while one is already pending in HOLD.
  always_comb begin
    w_drop = 1'b0;
    case (r_state)
      VALID:   w_drop = w_event;
      HOLD:    w_drop = w_event & r_pending;
      default: w_drop = 1'b0;
    endcase
  end

  assign w_handshake = (r_state == VALID) & data_ready;

  // Receiver FSM with registered outputs and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ack     <= 1'b0;
      r_overrun <= 1'b0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_event) begin
            r_data  <= req_data;
            r_valid <= 1'b1;
            r_state <= VALID;
          end
        end
        VALID: begin
          if (data_ready) begin
            r_valid <= 1'b0;
            r_ack   <= ~r_ack;
            r_cnt   <= HOLD_LOAD;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (w_event) begin
              r_pending <= 1'b1;
            end
          end else if (r_pending || w_event) begin
            // Source data is still stable: the source cannot launch again
            // before it sees the ack flip that started this HOLD.
            r_data    <= req_data;
            r_valid   <= 1'b1;
            r_pending <= 1'b0;
            r_state   <= VALID;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_valid   <= 1'b0;
          r_pending <= 1'b0;
        end
      endcase

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign ack_toggle = r_ack;
  assign overrun    = r_overrun;

`ifdef STROBE_ACK_RX_STATS_EN
  logic [RX_CNT_W-1:0]  r_rx_count;
  logic [OVR_CNT_W-1:0] r_ovr_count;

  // Handshake counter wraps; drop counter saturates. overrun_clr leaves both alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_count  <= '0;
      r_ovr_count <= '0;
    end else begin
      if (w_handshake) begin
        r_rx_count <= r_rx_count + RX_CNT_W'(1);
      end
      if (w_drop) begin
        r_ovr_count <= sat_inc_ovr(r_ovr_count);
      end
    end
  end

  assign rx_count  = r_rx_count;
  assign ovr_count = r_ovr_count;
`else
  // Without statistics the handshake strobe has no consumer.
  logic w_unused_handshake;
  assign w_unused_handshake = w_handshake;
`endif

endmodule

// File: tb/tb_strobe_ack_rx.sv
module tb_strobe_ack_rx;

  localparam int WIDTH = 8;
  localparam int DELAY = 2;
  localparam int HOLD  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_toggle = 1'b0;
  logic [WIDTH-1:0] req_data = 8'h00;
  logic             data_ready = 1'b0;
  logic             overrun_clr = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             ack_toggle;
  logic             overrun;
`ifdef STROBE_ACK_RX_STATS_EN
  logic [15:0]      rx_count;
  logic [7:0]       ovr_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  strobe_ack_rx #(
    .WIDTH       (WIDTH),
    .DELAY       (DELAY),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_toggle  (req_toggle),
    .req_data    (req_data),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .ack_toggle  (ack_toggle),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`ifdef STROBE_ACK_RX_STATS_EN
    ,
    .rx_count    (rx_count),
    .ovr_count   (ovr_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: transaction-level view of the receiver.
  bit             hist[$];     // req_toggle as seen at each rising edge
  bit             m_have;      // a word is waiting for the consumer
  bit             m_inhold;    // post-ack quiet period in progress
  int             m_hold_left; // quiet-period cycles still to run
  bit             m_pend;      // one event remembered during the quiet period
  bit             m_ack;
  bit             m_ovr;
  logic [7:0]     m_data;
  int             m_rx;
  int             m_ovrcnt;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DELAY + 2; i++) hist.push_back(1'b0);
    m_have = 0; m_inhold = 0; m_hold_left = 0; m_pend = 0;
    m_ack = 0; m_ovr = 0; m_data = 8'h00; m_rx = 0; m_ovrcnt = 0;
  endtask

  task automatic model_step();
    bit ev;
    bit drop;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_back(req_toggle);
      if (hist.size() > DELAY + 2) void'(hist.pop_front());
      // A flip seen at edge k-DELAY reaches the receiver's logic at edge k.
      ev = hist[hist.size() - 1 - DELAY] ^ hist[hist.size() - 2 - DELAY];
      drop = 0;
      if (m_have) begin
        if (ev) drop = 1;
        if (data_ready) begin
          m_have = 0; m_ack = !m_ack; m_inhold = 1; m_hold_left = HOLD - 1;
          m_rx = (m_rx + 1) % 65536;
        end
      end else if (m_inhold) begin
        if (ev && m_pend) drop = 1;
        if (m_hold_left > 0) begin
          m_hold_left--;
          if (ev) m_pend = 1;
        end else begin
          m_inhold = 0;
          if (m_pend || ev) begin
            m_data = req_data; m_have = 1; m_pend = 0;
          end
        end
      end else if (ev) begin
        m_data = req_data; m_have = 1;
      end
      if (drop) begin
        m_ovr = 1;
        if (m_ovrcnt < 255) m_ovrcnt++;
      end else if (overrun_clr) begin
        m_ovr = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_valid(input int budget, output int edges);
    edges = 0;
    while (data_valid !== 1'b1 && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_toggle = 1'b0;
    data_ready = 1'b0;
    overrun_clr = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    n_cmp++;
    if ({data_valid, ack_toggle, overrun} !== 3'b000 || data_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b ack=%b ovr=%b data=%h expected 0 0 0 00",
               data_valid, ack_toggle, overrun, data_out);
    end
`ifdef STROBE_ACK_RX_STATS_EN
    n_cmp++;
    if (rx_count !== 16'd0 || ovr_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_counts: got rx=%0d ovr=%0d expected 0 0", rx_count, ovr_count);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int edges;
    req_data = 8'hA5;
    req_toggle = ~req_toggle;
    data_ready = 1'b1;
    wait_valid(20, edges);
    n_cmp++;
    if (data_valid !== 1'b1 || edges != DELAY + 1) begin
      n_bad++;
      $display("FAIL basic_latency: got valid=%b after %0d edges expected valid=1 after %0d",
               data_valid, edges, DELAY + 1);
    end
    n_cmp++;
    if (data_out !== 8'hA5) begin
      n_bad++;
      $display("FAIL basic_data: got %h expected a5", data_out);
    end
    tick();
    n_cmp++;
    if (data_valid !== 1'b0 || ack_toggle !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ack: got valid=%b ack=%b expected valid=0 ack=1", data_valid, ack_toggle);
    end
    data_ready = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_hold_data();
    int   edges;
    logic ack_before;
    req_data = 8'h3C;
    req_toggle = ~req_toggle;
    data_ready = 1'b0;
    wait_valid(20, edges);
    n_cmp++;
    if (data_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_timeout: got valid=%b expected 1 within 20 edges", data_valid);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got valid=%b data=%h expected valid=1 data=3c",
                 i, data_valid, data_out);
      end
    end
    ack_before = ack_toggle;
    data_ready = 1'b1;
    tick();
    n_cmp++;
    if (ack_toggle !== ~ack_before || data_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: got ack=%b valid=%b expected ack=%b valid=0",
               ack_toggle, data_valid, ~ack_before);
    end
    data_ready = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_pending();
    int edges;
    req_data = 8'h11;
    req_toggle = ~req_toggle;
    wait_valid(20, edges);
    // Launch the next word now; it reaches the receiver just after the ack flip.
    req_data = 8'h5A;
    req_toggle = ~req_toggle;
    tick();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pending_in_hold: got valid=%b expected 0", data_valid);
    end
    tick();
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h5A || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL pending_taken: got valid=%b data=%h ovr=%b expected 1 5a 0",
               data_valid, data_out, overrun);
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_overrun();
    int edges;
    req_data = 8'hC3;
    req_toggle = ~req_toggle;
    data_ready = 1'b0;
    repeat (4) tick();
    req_data = 8'hD4;
    req_toggle = ~req_toggle;
    repeat (DELAY + 1) tick();
    n_cmp++;
    if (overrun !== 1'b1 || data_out !== 8'hC3 || data_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set: got ovr=%b data=%h valid=%b expected 1 c3 1",
               overrun, data_out, data_valid);
    end
    req_data = 8'hE5;
    req_toggle = ~req_toggle;
    repeat (DELAY) tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set_beats_clr: got %b expected 1", overrun);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0 || data_out !== 8'hC3) begin
      n_bad++;
      $display("FAIL overrun_clr: got ovr=%b data=%h expected 0 c3", overrun, data_out);
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    int edges;
    req_data = 8'h77;
    req_toggle = ~req_toggle;
    data_ready = 1'b0;
    wait_valid(20, edges);
    req_toggle = ~req_toggle;
    repeat (DELAY + 1) tick();
    n_cmp++;
    if (overrun !== 1'b1 || ack_toggle !== 1'b1 || data_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_setup: got ovr=%b ack=%b valid=%b expected 1 1 1",
               overrun, ack_toggle, data_valid);
    end
    #2;
    rst_n = 1'b0;
    req_toggle = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({data_valid, ack_toggle, overrun} !== 3'b000) begin
      n_bad++;
      $display("FAIL areset_immediate: got valid=%b ack=%b ovr=%b expected 0 0 0",
               data_valid, ack_toggle, overrun);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    req_data = 8'h9E;
    req_toggle = ~req_toggle;
    data_ready = 1'b1;
    wait_valid(20, edges);
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h9E || edges != DELAY + 1) begin
      n_bad++;
      $display("FAIL areset_fresh: got valid=%b data=%h edges=%0d expected 1 9e %0d",
               data_valid, data_out, edges, DELAY + 1);
    end
    tick();
    n_cmp++;
    if (ack_toggle !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_ack: got %b expected 1", ack_toggle);
    end
    data_ready = 1'b0;
    repeat (4) tick();
  endtask

`ifdef STROBE_ACK_RX_STATS_EN
  task automatic test_stats();
    int edges;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      req_data = 8'($urandom);
      req_toggle = ~req_toggle;
      data_ready = 1'b1;
      wait_valid(20, edges);
      tick();
      repeat (4) tick();
    end
    data_ready = 1'b0;
    req_toggle = ~req_toggle;
    wait_valid(20, edges);
    repeat (2) begin
      req_toggle = ~req_toggle;
      repeat (DELAY + 1) tick();
    end
    n_cmp++;
    if (rx_count !== 16'd3 || ovr_count !== 8'd2) begin
      n_bad++;
      $display("FAIL stats_small: got rx=%0d ovr=%0d expected 3 2", rx_count, ovr_count);
    end
    for (int i = 0; i < 300; i++) begin
      req_toggle = ~req_toggle;
      tick();
    end
    repeat (DELAY + 1) tick();
    n_cmp++;
    if (ovr_count !== 8'd255 || rx_count !== 16'd3) begin
      n_bad++;
      $display("FAIL stats_saturate: got rx=%0d ovr=%0d expected 3 255", rx_count, ovr_count);
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    repeat (4) tick();
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 7) == 0) begin
        req_toggle = ~req_toggle;
        req_data = 8'($urandom);
      end
      data_ready = 1'($urandom_range(0, 1));
      overrun_clr = ($urandom_range(0, 15) == 0);
      tick();
      n_cmp++;
      if (data_valid !== m_have || data_out !== m_data ||
          ack_toggle !== m_ack || overrun !== m_ovr) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got valid=%b data=%h ack=%b ovr=%b expected %b %h %b %b",
                 cyc, data_valid, data_out, ack_toggle, overrun, m_have, m_data, m_ack, m_ovr);
      end
`ifdef STROBE_ACK_RX_STATS_EN
      n_cmp++;
      if (rx_count !== 16'(m_rx) || ovr_count !== 8'(m_ovrcnt)) begin
        n_bad++;
        $display("FAIL random_counts%0d: got rx=%0d ovr=%0d expected %0d %0d",
                 cyc, rx_count, ovr_count, m_rx, m_ovrcnt);
      end
`endif
    end
    data_ready = 1'b0;
    overrun_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_basic();
    test_hold_data();
    test_pending();
    test_overrun();
    test_async_reset();
`ifdef STROBE_ACK_RX_STATS_EN
    test_stats();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
